// File: rtl/ddr_burst_sequencer.sv
// ddr_burst_sequencer: issues capture-enable pulses to a DDR-to-SDR converter,
// packs each returned lane pair into one word and buffers the words in a
// small first-word-fall-through FIFO with a valid/ready output. Issue is
// credit-limited so buffered plus in-flight words never exceed the FIFO depth.
module ddr_burst_sequencer #(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PIPE_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    burst_len,
  output logic                cap_en,
  input  logic [DATA_W-1:0]   sdr_data_0,
  input  logic [DATA_W-1:0]   sdr_data_1,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IF_W  = $clog2(PIPE_LAT + 1);
  localparam int SUM_W = ((CNT_W > IF_W) ? CNT_W : IF_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_count_q, fifo_count_d;
  logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic [IF_W-1:0]     inflight;
  logic [SUM_W-1:0]    occupancy;
  logic                credit_ok;
  logic                push;
  logic                pop;

  // Number of captures still travelling through the converter pipeline.
  function automatic logic [IF_W-1:0] popcount(input logic [PIPE_LAT-1:0] v);
    logic [IF_W-1:0] c;
    c = '0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      c = c + IF_W'(v[i]);
    end
    return c;
  endfunction

  // Credit, handshake and FIFO head: everything here depends on registers,
  // so cap_en/out_valid/out_data are glitch-free decodes of state.
  always_comb begin
    inflight  = popcount(vld_q);
    occupancy = SUM_W'(fifo_count_q) + SUM_W'(inflight);
    credit_ok = (occupancy < SUM_W'(FIFO_DEPTH));
    cap_en    = (state_q == S_ISSUE) && credit_ok;
    push      = vld_q[PIPE_LAT-1];
    out_valid = (fifo_count_q != '0);
    pop       = out_valid && out_ready;
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

  // Next state of the in-flight shift register and the FIFO bookkeeping.
  always_comb begin
    vld_d        = (vld_q << 1) | PIPE_LAT'(cap_en);
    wr_ptr_d     = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d     = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    fifo_count_d = fifo_count_q;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // Burst control FSM: next state, latched length and issue counter.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            len_d    = burst_len;
            issued_d = '0;
            state_d  = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (cap_en) begin
          issued_d = issued_q + LEN_W'(1);
          // len_q is never zero here, so len_q - 1 cannot wrap.
          if (issued_q == len_q - LEN_W'(1)) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Looking at the post-pop count lets done follow the last pop directly.
        if ((inflight == '0) && (fifo_count_d == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers; reset drops every buffered and in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      issued_q     <= '0;
      vld_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      vld_q        <= vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // FIFO storage: data only, validity is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {sdr_data_1, sdr_data_0};
    end
  end

endmodule

// File: tb/tb_ddr_burst_sequencer.sv
// Directed bench for ddr_burst_sequencer: a PIPE_LAT=1 instance for the
// directed scenarios and a PIPE_LAT=3 instance for random back-pressure.
module tb_ddr_burst_sequencer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start, out_ready, cap_en, out_valid, busy, done;
  logic [7:0]  burst_len, sdr0, sdr1;
  logic [15:0] out_data;

  logic        start3, ready3, cap3, valid3, busy3, done3;
  logic [7:0]  len3, s30, s31;
  logic [15:0] data3;

  logic [15:0] tbl [0:511];

  int n_cmp = 0;
  int n_mis = 0;

  ddr_burst_sequencer #(.DATA_W(8), .LEN_W(8), .FIFO_DEPTH(DEPTH), .PIPE_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .cap_en(cap_en),
    .sdr_data_0(sdr0), .sdr_data_1(sdr1), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done));

  ddr_burst_sequencer #(.DATA_W(8), .LEN_W(8), .FIFO_DEPTH(DEPTH), .PIPE_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .burst_len(len3), .cap_en(cap3),
    .sdr_data_0(s30), .sdr_data_1(s31), .out_data(data3), .out_valid(valid3),
    .out_ready(ready3), .busy(busy3), .done(done3));

  // Converter models: pair k appears PIPE_LAT cycles after its cap_en cycle.
  logic       mv1;
  int         n1;
  logic [2:0] mv3;
  int         n3;

  always @(posedge clk) begin
    if (rst) begin
      mv1 <= 1'b0;
      n1  <= 0;
      mv3 <= 3'b000;
      n3  <= 0;
    end else begin
      if (mv1) n1 <= n1 + 1;
      mv1 <= cap_en;
      if (mv3[2]) n3 <= n3 + 1;
      mv3 <= {mv3[1:0], cap3};
    end
  end

  assign {sdr1, sdr0} = tbl[n1];
  assign {s31, s30}   = tbl[n3];

  // Output monitors: collect popped words, done pulses and FIFO occupancy.
  logic [15:0] rx  [0:1023];
  logic [15:0] rx3 [0:1023];
  int rx_n = 0, rx3_n = 0, done_n = 0, done3_n = 0;
  int maxc = 0, maxc3 = 0, ovf = 0, ovf3 = 0;

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      rx[rx_n] <= out_data;
      rx_n     <= rx_n + 1;
    end
    if (valid3 === 1'b1 && ready3 === 1'b1) begin
      rx3[rx3_n] <= data3;
      rx3_n      <= rx3_n + 1;
    end
    if (done === 1'b1)  done_n  <= done_n + 1;
    if (done3 === 1'b1) done3_n <= done3_n + 1;
    if (int'(dut.fifo_count_q) > maxc)   maxc  <= int'(dut.fifo_count_q);
    if (int'(dut3.fifo_count_q) > maxc3) maxc3 <= int'(dut3.fifo_count_q);
    if (dut.push === 1'b1 && int'(dut.fifo_count_q) == DEPTH)   ovf  <= ovf + 1;
    if (dut3.push === 1'b1 && int'(dut3.fifo_count_q) == DEPTH) ovf3 <= ovf3 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int d0, input int bound);
    int k;
    k = 0;
    while (done_n == d0 && k < bound) begin
      step();
      k++;
    end
    chk(tag, 32'(done_n > d0), 32'd1);
  endtask

  logic [15:0] exp4 [4];
  int rx0, d0, base, capn, k3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) tbl[i] = {8'(i) ^ 8'hC3, 8'(i * 7 + 1)};
    tbl[0] = 16'h55AA; tbl[1] = 16'h00FF; tbl[2] = 16'h3412; tbl[3] = 16'h7856;
    exp4[0] = 16'h55AA; exp4[1] = 16'h00FF; exp4[2] = 16'h3412; exp4[3] = 16'h7856;

    // Reset with a start request held during reset.
    rst = 1'b1; start = 1'b1; burst_len = 8'd4; out_ready = 1'b0;
    start3 = 1'b0; len3 = 8'd0; ready3 = 1'b0;
    step();
    chk("rst_outs_e1", {cap_en, busy, done, out_valid, out_data}, 32'd0);
    step();
    chk("rst_outs_e2", {cap_en, busy, done, out_valid, out_data}, 32'd0);
    chk("rst_outs_dut3", {cap3, busy3, done3, valid3, data3}, 32'd0);
    rst = 1'b0; start = 1'b0;
    step();
    chk("rst_no_burst", {busy, cap_en}, 32'd0);

    // Basic burst of four with out_ready held high.
    out_ready = 1'b1; start = 1'b1; burst_len = 8'd4; d0 = done_n;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) start = 1'b0;
      chk("basic_cap", cap_en, 32'(c <= 4));
      chk("basic_done", done, 32'(c == 7));
      chk("basic_vld", out_valid, 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("basic_data", out_data, exp4[c-3]);
    end
    chk("basic_done_n", done_n - d0, 32'd1);

    // Back-pressure: length 10, out_ready low until cycle 12.
    out_ready = 1'b0; start = 1'b1; burst_len = 8'd10;
    rx0 = rx_n; d0 = done_n; base = n1; capn = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (c == 12) out_ready = 1'b1;
      if (cap_en) capn++;
      chk("bp_cap", cap_en, 32'(c <= 4));
    end
    chk("bp_cap_n", capn, 32'd4);
    wait_done("bp_done_seen", d0, 200);
    chk("bp_words", rx_n - rx0, 32'd10);
    for (int k = 0; k < 10; k++) chk("bp_word", rx[rx0+k], tbl[base+k]);
    chk("bp_maxcnt", maxc, 32'd4);

    // Zero-length burst.
    start = 1'b1; burst_len = 8'd0; d0 = done_n;
    step();
    start = 1'b0;
    chk("zl_done_c1", done, 32'd1);
    chk("zl_cap_c1", cap_en, 32'd0);
    chk("zl_busy_c1", busy, 32'd1);
    step();
    chk("zl_busy_c2", {busy, done, cap_en}, 32'd0);

    // Length-3 burst with a second start pulsed during ISSUE.
    start = 1'b1; burst_len = 8'd3; rx0 = rx_n; d0 = done_n; base = n1;
    step();
    start = 1'b0;
    step();
    chk("ign_in_issue", cap_en, 32'd1);
    start = 1'b1; burst_len = 8'd5;
    step();
    start = 1'b0;
    wait_done("ign_done_seen", d0, 100);
    for (int c = 0; c < 3; c++) begin
      chk("ign_idle", busy, 32'd0);
      step();
    end
    chk("ign_done_n", done_n - d0, 32'd1);
    chk("ign_words", rx_n - rx0, 32'd3);
    for (int k = 0; k < 3; k++) chk("ign_word", rx[rx0+k], tbl[base+k]);

    // Reset in cycle 4 of a length-8 burst, then a length-2 burst.
    start = 1'b1; burst_len = 8'd8;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_cap", cap_en, 32'd0);
    chk("mr_vld", out_valid, 32'd0);
    chk("mr_busy", busy, 32'd0);
    chk("mr_data", out_data, 32'd0);
    step();
    chk("mr_idle", busy, 32'd0);
    rx0 = rx_n; d0 = done_n; base = n1;
    start = 1'b1; burst_len = 8'd2;
    step();
    start = 1'b0;
    wait_done("mr_done_seen", d0, 100);
    repeat (5) step();
    chk("mr_words", rx_n - rx0, 32'd2);
    for (int k = 0; k < 2; k++) chk("mr_word", rx[rx0+k], tbl[base+k]);

    // Random back-pressure on the PIPE_LAT=3 instance, 255-word burst.
    rx0 = rx3_n; d0 = done3_n; base = n3;
    start3 = 1'b1; len3 = 8'd255;
    step();
    start3 = 1'b0;
    k3 = 0;
    while (done3_n == d0 && k3 < 3000) begin
      ready3 = 1'($urandom_range(0, 1));
      step();
      k3++;
    end
    chk("rnd_done_seen", 32'(done3_n > d0), 32'd1);
    repeat (10) begin
      ready3 = 1'($urandom_range(0, 1));
      step();
    end
    chk("rnd_done_n", done3_n - d0, 32'd1);
    chk("rnd_words", rx3_n - rx0, 32'd255);
    for (int k = 0; k < 255; k++) chk("rnd_word", rx3[rx0+k], tbl[base+k]);
    chk("rnd_no_ovf", ovf3, 32'd0);
    chk("rnd_maxcnt_ok", 32'(maxc3 <= DEPTH), 32'd1);
    chk("no_ovf", ovf, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
